// File: rtl/flappy_game_ctrl.sv
// Flappy Bird game-state engine: bird physics, two scrolling pipes, collision and score.
// Optional feature macro: PIPE_RANDOM_GAP_EN (LFSR-driven pipe gap height on wrap).
module flappy_game_ctrl #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int BIRD_X   = 100,
    parameter int BIRD_W   = 16,
    parameter int BIRD_H   = 16,
    parameter int PIPE_W   = 40,
    parameter int GAP_H    = 120,
    parameter int GRAVITY  = 1,
    parameter int FLAP_VEL = 8,
    parameter int VMAX     = 8
) (
    input  logic        game_clk,
    input  logic        reset,
    input  logic        flap,
    output logic [10:0] bird_x,
    output logic [10:0] bird_y,
    output logic [10:0] pipe1_x,
    output logic [10:0] pipe1_y,
    output logic [10:0] pipe2_x,
    output logic [10:0] pipe2_y,
    output logic [7:0]  score,
    output logic        playing,
    output logic        game_over
);

    typedef enum logic [1:0] {IDLE, PLAY, DEAD} state_t;

    localparam logic [10:0]        BIRD_Y_RST  = 11'd240;
    localparam logic [10:0]        PIPE1_X_RST = 11'd319;
    localparam logic [10:0]        PIPE2_X_RST = 11'd639;
    localparam logic [10:0]        PIPE1_Y_RST = 11'd250;
    localparam logic [10:0]        PIPE2_Y_RST = 11'd200;
    localparam logic [10:0]        PIPE_X_WRAP = 11'(SCREEN_W - 1);
    localparam logic signed [5:0]  FLAP_S      = 6'(FLAP_VEL);
    localparam logic signed [5:0]  VMAX_S      = 6'(VMAX);
    localparam logic signed [5:0]  GRAV_S      = 6'(GRAVITY);

    state_t             state_q, state_d;
    logic [10:0]        bird_y_q, bird_y_d;
    logic signed [5:0]  vel_q, vel_d;
    logic [10:0]        pipe1_x_q, pipe1_x_d, pipe1_y_q, pipe1_y_d;
    logic [10:0]        pipe2_x_q, pipe2_x_d, pipe2_y_q, pipe2_y_d;
    logic [7:0]         score_q, score_d;
    logic               playing_q, playing_d;
    logic               game_over_q, game_over_d;
    logic               flap_q, flap_d;

    logic               flap_edge;
    logic [11:0]        bird_sum;
    logic signed [5:0]  vel_inc;
    logic               collision;
    logic               pipe1_wrap, pipe2_wrap;
    logic [10:0]        gap1_new, gap2_new;
    logic [8:0]         score_sum;

    // Box-vs-pipe test in 12 bits so pipe_x + PIPE_W never wraps.
    function automatic logic pipe_hit(input logic [10:0] px, input logic [10:0] py,
                                      input logic [10:0] by);
        logic x_ovl, out_gap;
        x_ovl   = (12'(BIRD_X + BIRD_W) > {1'b0, px}) &&
                  (12'(BIRD_X) < ({1'b0, px} + 12'(PIPE_W)));
        out_gap = ({1'b0, by} < ({1'b0, py} - 12'(GAP_H / 2))) ||
                  (({1'b0, by} + 12'(BIRD_H)) > ({1'b0, py} + 12'(GAP_H / 2)));
        return x_ovl && out_gap;
    endfunction

    assign pipe1_wrap = (pipe1_x_q == 11'd0);
    assign pipe2_wrap = (pipe2_x_q == 11'd0);

`ifdef PIPE_RANDOM_GAP_EN
    logic [7:0] lfsr_q, lfsr_d;

    assign lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign gap1_new = 11'd100 + {3'b000, lfsr_q};
    assign gap2_new = (pipe1_wrap && pipe2_wrap)
                    ? 11'd100 + {3'b000, lfsr_q[3:0], lfsr_q[7:4]}
                    : 11'd100 + {3'b000, lfsr_q};
`else
    assign gap1_new = PIPE1_Y_RST;
    assign gap2_new = PIPE2_Y_RST;
`endif

    assign flap_edge = flap & ~flap_q;
    assign bird_sum  = {1'b0, bird_y_q} + {{6{vel_q[5]}}, vel_q};
    assign vel_inc   = vel_q + GRAV_S;
    assign score_sum = {1'b0, score_q} + 9'(pipe1_x_q == 11'(BIRD_X))
                                       + 9'(pipe2_x_q == 11'(BIRD_X));
    assign collision = (({1'b0, bird_y_q} + 12'(BIRD_H)) >= 12'(SCREEN_H)) ||
                       pipe_hit(pipe1_x_q, pipe1_y_q, bird_y_q) ||
                       pipe_hit(pipe2_x_q, pipe2_y_q, bird_y_q);

    always_comb begin
        state_d   = state_q;
        bird_y_d  = bird_y_q;
        vel_d     = vel_q;
        pipe1_x_d = pipe1_x_q;
        pipe1_y_d = pipe1_y_q;
        pipe2_x_d = pipe2_x_q;
        pipe2_y_d = pipe2_y_q;
        score_d   = score_q;
        flap_d    = flap;
        case (state_q)
            IDLE: begin
                if (flap_edge) begin
                    state_d = PLAY;
                    score_d = 8'd0;
                    vel_d   = -FLAP_S;
                end
            end
            PLAY: begin
                // A collision tick freezes everything so the crash frame stays on screen.
                if (collision) begin
                    state_d = DEAD;
                end else begin
                    bird_y_d = bird_sum[11] ? 11'd0 : bird_sum[10:0];
                    if (flap_edge)
                        vel_d = -FLAP_S;
                    else
                        vel_d = (vel_inc > VMAX_S) ? VMAX_S : vel_inc;
                    if (pipe1_wrap) begin
                        pipe1_x_d = PIPE_X_WRAP;
                        pipe1_y_d = gap1_new;
                    end else begin
                        pipe1_x_d = pipe1_x_q - 11'd1;
                    end
                    if (pipe2_wrap) begin
                        pipe2_x_d = PIPE_X_WRAP;
                        pipe2_y_d = gap2_new;
                    end else begin
                        pipe2_x_d = pipe2_x_q - 11'd1;
                    end
                    score_d = score_sum[8] ? 8'hFF : score_sum[7:0];
                end
            end
            DEAD: begin
                if (flap_edge) begin
                    state_d   = IDLE;
                    bird_y_d  = BIRD_Y_RST;
                    vel_d     = 6'sd0;
                    pipe1_x_d = PIPE1_X_RST;
                    pipe1_y_d = PIPE1_Y_RST;
                    pipe2_x_d = PIPE2_X_RST;
                    pipe2_y_d = PIPE2_Y_RST;
                end
            end
            default: state_d = IDLE;
        endcase
        playing_d   = (state_d == PLAY);
        game_over_d = (state_d == DEAD);
    end

    always_ff @(posedge game_clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bird_y_q    <= BIRD_Y_RST;
            vel_q       <= 6'sd0;
            pipe1_x_q   <= PIPE1_X_RST;
            pipe1_y_q   <= PIPE1_Y_RST;
            pipe2_x_q   <= PIPE2_X_RST;
            pipe2_y_q   <= PIPE2_Y_RST;
            score_q     <= 8'd0;
            playing_q   <= 1'b0;
            game_over_q <= 1'b0;
            flap_q      <= 1'b1;
`ifdef PIPE_RANDOM_GAP_EN
            lfsr_q      <= 8'hA5;
`endif
        end else begin
            state_q     <= state_d;
            bird_y_q    <= bird_y_d;
            vel_q       <= vel_d;
            pipe1_x_q   <= pipe1_x_d;
            pipe1_y_q   <= pipe1_y_d;
            pipe2_x_q   <= pipe2_x_d;
            pipe2_y_q   <= pipe2_y_d;
            score_q     <= score_d;
            playing_q   <= playing_d;
            game_over_q <= game_over_d;
            flap_q      <= flap_d;
`ifdef PIPE_RANDOM_GAP_EN
            lfsr_q      <= lfsr_d;
`endif
        end
    end

    assign bird_x    = 11'(BIRD_X);
    assign bird_y    = bird_y_q;
    assign pipe1_x   = pipe1_x_q;
    assign pipe1_y   = pipe1_y_q;
    assign pipe2_x   = pipe2_x_q;
    assign pipe2_y   = pipe2_y_q;
    assign score     = score_q;
    assign playing   = playing_q;
    assign game_over = game_over_q;

endmodule
